// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / receiver / display path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

  // Receiver measurement states.
  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    LOW,
    LOST,
    STUCK
  } pwm_rx_state_t;

  // Speed-level width shared by the generator, this decoder and the display decoder.
  localparam int PWM_LEVEL_W = 4;

endpackage

// File: rtl/pwm_level_div.sv
// Bit-serial restoring divider: quot = floor(num * 2**OUT_W / den), requires num < den.
// Latency: OUT_W cycles after the start cycle; done/quot are valid in the last busy cycle.
// Backpressure: start is ignored while busy; the caller must check busy before starting.
//
// Ports:
//   clk, rstN      clock and synchronous active-low reset
//   start          load num/den and begin a division (ignored while busy)
//   num, den       high time and period; num < den
//   busy           division in flight (includes the cycle that raises done)
//   done           final iteration this cycle; quot is valid alongside it
//   quot           quotient, OUT_W bits
module pwm_level_div #(
  parameter int CNT_W = 16,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic [CNT_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] quot
);

  localparam int            IW      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [IW-1:0] LAST_IT = IW'(OUT_W - 1);

  logic             busy_q, busy_d;
  logic [IW-1:0]    it_q, it_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] den_q, den_d;
  logic [OUT_W-1:0] quot_q, quot_d;

  logic [CNT_W:0]   rem_sh;
  logic             ge;
  logic [OUT_W-1:0] quot_step;

  always_comb begin
    // Because num < den the partial remainder always stays below den, so the
    // dividend's low OUT_W zero bits can be shifted in one per iteration and
    // only OUT_W quotient bits are ever non-zero.
    rem_sh    = {rem_q, 1'b0};
    ge        = (rem_sh >= {1'b0, den_q});
    quot_step = {quot_q[OUT_W-2:0], ge};

    busy_d = busy_q;
    it_d   = it_q;
    rem_d  = rem_q;
    den_d  = den_q;
    quot_d = quot_q;

    if (busy_q) begin
      rem_d  = ge ? CNT_W'(rem_sh - {1'b0, den_q}) : CNT_W'(rem_sh);
      quot_d = quot_step;
      it_d   = it_q + 1'b1;
      if (it_q == LAST_IT) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      busy_d = 1'b1;
      it_d   = '0;
      rem_d  = num;
      den_d  = den;
      quot_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      busy_q <= 1'b0;
      it_q   <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
    end else begin
      busy_q <= busy_d;
      it_q   <= it_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      quot_q <= quot_d;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (it_q == LAST_IT);
  assign quot = quot_step;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the speed level from a PWM waveform and flags loss / stuck-high input.
// Latency: level_valid and duty_level update OUT_W+1 cycles after the capturing rise of s_pwm.
// Backpressure: none; a capture arriving while the divider is busy is dropped.
//
// Ports:
//   clk, rstN      clock and synchronous active-low reset
//   pwm_in         asynchronous PWM input
//   duty_level     last recovered level (registered)
//   level_valid    one-cycle pulse when duty_level is updated
//   signal_lost    no edge for TIMEOUT cycles while low/idle
//   stuck_high     input held high for TIMEOUT cycles
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096,
  parameter int OUT_W   = PWM_LEVEL_W
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             pwm_in,
  output logic [OUT_W-1:0] duty_level,
  output logic             level_valid,
  output logic             signal_lost,
  output logic             stuck_high
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [OUT_W-1:0] LVL_MAX  = '1;

  logic             sync1_q, sync1_d;
  logic             s_pwm_q, s_pwm_d;
  logic             s_prev_q, s_prev_d;
  pwm_rx_state_t    state_q, state_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [OUT_W-1:0] duty_level_q, duty_level_d;
  logic             level_valid_q, level_valid_d;
  logic             signal_lost_q, signal_lost_d;
  logic             stuck_high_q, stuck_high_d;

  logic             rise, fall, tmo;
  logic [CNT_W-1:0] high_inc, per_inc;
  logic             div_start, div_busy, div_done;
  logic [OUT_W-1:0] div_quot;

  pwm_level_div #(
    .CNT_W (CNT_W),
    .OUT_W (OUT_W)
  ) u_div (
    .clk   (clk),
    .rstN  (rstN),
    .start (div_start),
    .num   (high_cnt_q),
    .den   (per_cnt_q),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_comb begin
    sync1_d  = pwm_in;
    s_pwm_d  = sync1_q;
    s_prev_d = s_pwm_q;

    rise     = s_pwm_q & ~s_prev_q;
    fall     = ~s_pwm_q & s_prev_q;
    high_inc = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CNT_ONE;
    per_inc  = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
    // The cycle whose increment would make per_cnt reach TIMEOUT.
    tmo      = (per_cnt_q == TMO_LAST);

    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    per_cnt_d     = per_cnt_q;
    duty_level_d  = duty_level_q;
    level_valid_d = 1'b0;
    signal_lost_d = signal_lost_q;
    stuck_high_d  = stuck_high_q;
    div_start     = 1'b0;

    if (div_done) begin
      duty_level_d  = div_quot;
      level_valid_d = 1'b1;
    end

    // Edges are tested before the timeout so an edge in the timeout cycle wins.
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = HIGH;
          high_cnt_d = CNT_ONE;
          per_cnt_d  = CNT_ONE;
        end else if (tmo) begin
          state_d       = LOST;
          signal_lost_d = 1'b1;
          duty_level_d  = '0;
          level_valid_d = 1'b1;
        end else begin
          per_cnt_d = per_inc;
        end
      end
      HIGH: begin
        per_cnt_d = per_inc;
        if (fall) begin
          state_d = LOW;
        end else if (tmo) begin
          state_d       = STUCK;
          stuck_high_d  = 1'b1;
          duty_level_d  = LVL_MAX;
          level_valid_d = 1'b1;
        end else begin
          high_cnt_d = high_inc;
        end
      end
      LOW: begin
        if (rise) begin
          // high_cnt == 0 marks a LOW entered from STUCK: that rise only re-arms.
          div_start  = (high_cnt_q != '0) && !div_busy;
          state_d    = HIGH;
          high_cnt_d = CNT_ONE;
          per_cnt_d  = CNT_ONE;
        end else if (tmo) begin
          state_d       = LOST;
          signal_lost_d = 1'b1;
          duty_level_d  = '0;
          level_valid_d = 1'b1;
        end else begin
          per_cnt_d = per_inc;
        end
      end
      LOST: begin
        if (rise) begin
          state_d       = HIGH;
          signal_lost_d = 1'b0;
          high_cnt_d    = CNT_ONE;
          per_cnt_d     = CNT_ONE;
        end
      end
      STUCK: begin
        if (fall) begin
          state_d      = LOW;
          stuck_high_d = 1'b0;
          high_cnt_d   = '0;
          per_cnt_d    = CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      sync1_q       <= 1'b0;
      s_pwm_q       <= 1'b0;
      s_prev_q      <= 1'b0;
      state_q       <= IDLE;
      high_cnt_q    <= '0;
      per_cnt_q     <= '0;
      duty_level_q  <= '0;
      level_valid_q <= 1'b0;
      signal_lost_q <= 1'b0;
      stuck_high_q  <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      s_pwm_q       <= s_pwm_d;
      s_prev_q      <= s_prev_d;
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      per_cnt_q     <= per_cnt_d;
      duty_level_q  <= duty_level_d;
      level_valid_q <= level_valid_d;
      signal_lost_q <= signal_lost_d;
      stuck_high_q  <= stuck_high_d;
    end
  end

  assign duty_level  = duty_level_q;
  assign level_valid = level_valid_q;
  assign signal_lost = signal_lost_q;
  assign stuck_high  = stuck_high_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder: waveform-level reference model feeding a
// scoreboard of expected (level, flags, time) pulses, popped by an independent monitor.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_pwm_duty_decoder;

  localparam int  CNT_W   = 16;
  localparam int  TIMEOUT = 4096;
  localparam int  OUT_W   = 4;
  localparam int  CLK     = 10;
  localparam int  STEPS   = 1 << OUT_W;

  localparam int M_IDLE  = 0;
  localparam int M_MEAS  = 1;
  localparam int M_LOST  = 2;
  localparam int M_STUCK = 3;
  localparam int M_REARM = 4;

  logic             clk;
  logic             rstN;
  logic             pwm_in;
  logic [OUT_W-1:0] duty_level;
  logic             level_valid;
  logic             signal_lost;
  logic             stuck_high;

  typedef struct {
    int  lvl;
    int  lost;
    int  stuck;
    time t;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (waveform-level view, times are drive times).
  int   m_mode;
  time  m_ref_t;
  int   m_high_len;
  bit   m_have_fall;
  time  m_busy_until;
  logic m_prev;

  pwm_duty_decoder #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .OUT_W   (OUT_W)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .pwm_in      (pwm_in),
    .duty_level  (duty_level),
    .level_valid (level_valid),
    .signal_lost (signal_lost),
    .stuck_high  (stuck_high)
  );

  initial begin
    clk = 1'b0;
    forever #(CLK/2) clk = ~clk;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic push(input int lvl, input int lost, input int stuck, input time t);
    exp_t e;
    e.lvl = lvl; e.lost = lost; e.stuck = stuck; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_mode       = M_IDLE;
    m_ref_t      = 0;
    m_high_len   = 0;
    m_have_fall  = 1'b0;
    m_busy_until = 0;
    m_prev       = 1'b0;
  endtask

  // One input sample driven at time t. A value driven at t is seen as an edge by the
  // DUT two clocks later, a capture result appears 7 clocks after the drive, and a
  // timeout flag 3 clocks after the drive of the sample that completes TIMEOUT cycles.
  task automatic model_bit(input logic b, input time t);
    bit rise, fall;
    int el;
    rise   = b && !m_prev;
    fall   = !b && m_prev;
    m_prev = b;
    el     = int'((t - m_ref_t) / CLK);
    case (m_mode)
      M_IDLE: begin
        if (rise) begin
          m_mode = M_MEAS; m_ref_t = t; m_have_fall = 1'b0;
        end
      end
      M_MEAS: begin
        if (rise) begin
          if (m_have_fall && t > m_busy_until) begin
            push((m_high_len * STEPS) / el, 0, 0, t + 7*CLK);
            m_busy_until = t + 4*CLK;
          end
          m_ref_t = t; m_have_fall = 1'b0;
        end else if (fall) begin
          m_high_len  = el;
          m_have_fall = 1'b1;
        end else if (el == TIMEOUT - 1) begin
          if (b) begin
            m_mode = M_STUCK; push(STEPS - 1, 0, 1, t + 3*CLK);
          end else begin
            m_mode = M_LOST; push(0, 1, 0, t + 3*CLK);
          end
        end
      end
      M_LOST: begin
        if (rise) begin
          m_mode = M_MEAS; m_ref_t = t; m_have_fall = 1'b0;
        end
      end
      M_STUCK: begin
        if (fall) begin
          m_mode = M_REARM; m_ref_t = t;
        end
      end
      default: begin
        if (rise) begin
          m_mode = M_MEAS; m_ref_t = t; m_have_fall = 1'b0;
        end else if (el == TIMEOUT - 1) begin
          m_mode = M_LOST; push(0, 1, 0, t + 3*CLK);
        end
      end
    endcase
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    pwm_in = b;
    model_bit(b, $time);
  endtask

  task automatic pwm_period(input int h, input int p);
    for (int i = 0; i < h; i++) drive_bit(1'b1);
    for (int i = 0; i < p - h; i++) drive_bit(1'b0);
  endtask

  // Monitor: every level_valid pulse must match the oldest expectation, at its time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].t < $time) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_pulse: no level_valid at t=%0t, expected level %0d", e.t, e.lvl);
      end
      if (level_valid === 1'b1) begin
        if (exp_q.size() > 0 && exp_q[0].t == $time) begin
          e = exp_q.pop_front();
          check("level_known", int'($isunknown(duty_level)), 0);
          check("duty_level", int'(duty_level), e.lvl);
          check("lost_at_pulse", int'(signal_lost), e.lost);
          check("stuck_at_pulse", int'(stuck_high), e.stuck);
        end else begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse at t=%0t: level %0d, expected none", $time, duty_level);
        end
      end
    end
  end

  initial begin
    #(CLK * 80000);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, p;
    rstN   = 1'b0;
    pwm_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_duty_level", int'(duty_level), 0);
    check("rst_level_valid", int'(level_valid), 0);
    check("rst_signal_lost", int'(signal_lost), 0);
    check("rst_stuck_high", int'(stuck_high), 0);
    rstN = 1'b1;
    repeat (3) drive_bit(1'b0);

    // Period 32, high 8: level 4 from the second rise on.
    repeat (5) pwm_period(8, 32);

    // Period 32 high 31 -> 15, then period 16 high 1 -> 1.
    repeat (3) pwm_period(31, 32);
    repeat (3) pwm_period(1, 16);

    // 50% waveform, then held low until signal loss.
    repeat (3) pwm_period(16, 32);
    repeat (TIMEOUT + 10) drive_bit(1'b0);
    check("lost_flag_set", int'(signal_lost), 1);
    check("lost_duty_zero", int'(duty_level), 0);
    repeat (4) drive_bit(1'b1);
    check("lost_cleared_by_rise", int'(signal_lost), 0);
    repeat (12) drive_bit(1'b1);
    repeat (16) drive_bit(1'b0);
    repeat (2) pwm_period(16, 32);

    // Held high until stuck, then recover with a 16/32 waveform.
    repeat (TIMEOUT + 10) drive_bit(1'b1);
    check("stuck_flag_set", int'(stuck_high), 1);
    check("stuck_duty_max", int'(duty_level), STEPS - 1);
    repeat (4) drive_bit(1'b0);
    check("stuck_cleared_by_fall", int'(stuck_high), 0);
    repeat (12) drive_bit(1'b0);
    repeat (3) pwm_period(16, 32);

    // Reset while the divider is busy with a capture.
    repeat (2) pwm_period(8, 32);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    @(negedge clk);
    rstN   = 1'b0;
    pwm_in = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].t > $time) exp_q.pop_back();
    model_reset();
    @(negedge clk);
    check("rst2_duty_level", int'(duty_level), 0);
    check("rst2_level_valid", int'(level_valid), 0);
    check("rst2_signal_lost", int'(signal_lost), 0);
    check("rst2_stuck_high", int'(stuck_high), 0);
    rstN = 1'b1;
    repeat (3) drive_bit(1'b0);
    repeat (3) pwm_period(8, 32);

    // Period 4, shorter than the divider latency: overruns are dropped.
    repeat (2) pwm_period(8, 32);
    for (int i = 0; i < 10; i++) pwm_period(int'($urandom_range(1, 3)), 4);
    repeat (2) pwm_period(8, 32);

    // Random periods, including short ones that overrun the divider.
    for (int i = 0; i < 40; i++) begin
      p = int'($urandom_range(2, 48));
      h = int'($urandom_range(1, p - 1));
      pwm_period(h, p);
    end
    repeat (12) drive_bit(1'b0);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
